pdp8_membus_ctrl: RTL and testbench

Sequencer that turns 12-bit word requests from the PDP-8 core into the nibble-serial cycles of the 8-pin external bus. It covers memory read/write through the off-chip address latch and SRAM, and IO read/write through the IO-select cycle. It sits between the CPU execution unit and the `io_out`/`io_in` pins. It tracks the last-latched high address half so that a repeated page skips one bus cycle.

---
 rtl/pdp8_bus_pkg.sv | 61 ++++++
 rtl/pdp8_membus_ctrl.sv | 154 +++++++++++++++
 tb/tb_pdp8_membus_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pdp8_bus_pkg.sv
// Shared types and pin encodings for the PDP-8 nibble-serial external bus.
// Contents: controller state enum, captured-request payload struct,
// bus-cycle prefix constants, read nibble indices and address helpers.
package pdp8_bus_pkg;

    localparam int unsigned WORD_W = 12;
    localparam int unsigned PAGE_W = 6;
    localparam int unsigned SEL_W  = 5;
    localparam int unsigned NIB_W  = 4;
    localparam int unsigned BUS_W  = 8;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LHI,
        ST_LLO,
        ST_IOSEL,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_WR0,
        ST_WR1,
        ST_WR2
    } state_e;

    // Request fields frozen at accept time.
    typedef struct packed {
        logic              we;
        logic              is_io;
        logic [WORD_W-1:0] addr;
        logic [SEL_W-1:0]  io_sel;
        logic [WORD_W-1:0] wdata;
    } xfer_t;

    // Address latch cycles: bit7=1 opens the external latch.
    localparam logic [1:0] PFX_LHI   = 2'b11;
    localparam logic [1:0] PFX_LLO   = 2'b10;
    // IO select cycle.
    localparam logic [2:0] PFX_IOSEL = 3'b011;
    // Write cycles; WR2 commits the assembled word.
    localparam logic [2:0] PFX_WR0   = 3'b000;
    localparam logic [2:0] PFX_WR1   = 3'b001;
    localparam logic [2:0] PFX_WR2   = 3'b010;

    // Read nibble selects: 0 -> [11:8], 1 -> [7:4], 2 -> [3:0].
    localparam logic [1:0] NIB_HI  = 2'd0;
    localparam logic [1:0] NIB_MID = 2'd1;
    localparam logic [1:0] NIB_LO  = 2'd2;

    localparam logic [BUS_W-1:0] BUS_IDLE = 8'h00;

    // High (page) half of a word address.
    function automatic logic [PAGE_W-1:0] page_of(input logic [WORD_W-1:0] a);
        return a[WORD_W-1 -: PAGE_W];
    endfunction

    // Low (offset) half of a word address.
    function automatic logic [PAGE_W-1:0] offs_of(input logic [WORD_W-1:0] a);
        return a[PAGE_W-1:0];
    endfunction

endpackage

// File: rtl/pdp8_membus_ctrl.sv
// Sequencer turning 12-bit CPU word requests into nibble-serial cycles on
// the 8-pin external bus (memory via off-chip address latch + SRAM, IO via
// an IO-select cycle). Tracks the last latched page so a repeated page can
// skip the LATCH_HI cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req, we, is_io        request valid / write select / IO select
//   addr, io_sel, wdata   request payload, captured on accept
//   ready                 idle, a request may be accepted
//   done                  one-cycle completion pulse
//   rdata                 last completed read word
//   bus_out, bus_in       pin bus drive / pin nibble input
module pdp8_membus_ctrl
    import pdp8_bus_pkg::*;
#(
    parameter bit HI_CACHE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic              is_io,
    input  logic [WORD_W-1:0] addr,
    input  logic [SEL_W-1:0]  io_sel,
    input  logic [WORD_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [WORD_W-1:0] rdata,
    output logic [BUS_W-1:0]  bus_out,
    input  logic [NIB_W-1:0]  bus_in
);

    state_e                  state_q, state_d;
    xfer_t                   xfer_q, xfer_d;
    logic [PAGE_W-1:0]       hi_q, hi_d;
    logic                    hi_vld_q, hi_vld_d;
    logic [2*NIB_W-1:0]      rd_buf_q, rd_buf_d;
    logic [WORD_W-1:0]       rdata_q, rdata_d;
    logic                    done_q, done_d;
    logic                    ready_q, ready_d;
    logic [BUS_W-1:0]        bus_q, bus_d;
    logic                    hit_c;

    // Pin encoding of the bus cycle driven while in a given state.
    function automatic logic [BUS_W-1:0] bus_enc(input state_e st, input xfer_t x);
        logic [BUS_W-1:0] enc;
        enc = BUS_IDLE;
        case (st)
            ST_LHI:   enc = {PFX_LHI, page_of(x.addr)};
            ST_LLO:   enc = {PFX_LLO, offs_of(x.addr)};
            ST_IOSEL: enc = {PFX_IOSEL, x.io_sel};
            ST_RD0:   enc = {1'b0, NIB_HI, 5'b0};
            ST_RD1:   enc = {1'b0, NIB_MID, 5'b0};
            ST_RD2:   enc = {1'b0, NIB_LO, 5'b0};
            ST_WR0:   enc = {PFX_WR0, 1'b1, x.wdata[3:0]};
            ST_WR1:   enc = {PFX_WR1, 1'b1, x.wdata[7:4]};
            ST_WR2:   enc = {PFX_WR2, 1'b1, x.wdata[11:8]};
            default:  enc = BUS_IDLE;
        endcase
        return enc;
    endfunction

    // Page hit: the external latch already holds this address's high half.
    assign hit_c = HI_CACHE && hi_vld_q && (page_of(addr) == hi_q);

    // Next-state, payload capture, read assembly and next output values.
    always_comb begin
        state_d  = state_q;
        xfer_d   = xfer_q;
        hi_d     = hi_q;
        hi_vld_d = hi_vld_q;
        rd_buf_d = rd_buf_q;
        rdata_d  = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    xfer_d.we     = we;
                    xfer_d.is_io  = is_io;
                    xfer_d.addr   = addr;
                    xfer_d.io_sel = io_sel;
                    xfer_d.wdata  = wdata;
                    if (is_io) begin
                        state_d = ST_IOSEL;
                    end else if (hit_c) begin
                        state_d = ST_LLO;
                    end else begin
                        state_d = ST_LHI;
                    end
                end
            end
            ST_LHI: begin
                hi_d     = page_of(xfer_q.addr);
                hi_vld_d = 1'b1;
                state_d  = ST_LLO;
            end
            ST_LLO, ST_IOSEL: begin
                state_d = xfer_q.we ? ST_WR0 : ST_RD0;
            end
            ST_RD0: begin
                rd_buf_d[2*NIB_W-1 -: NIB_W] = bus_in;
                state_d = ST_RD1;
            end
            ST_RD1: begin
                rd_buf_d[NIB_W-1:0] = bus_in;
                state_d = ST_RD2;
            end
            ST_RD2: begin
                // Publish the whole word at once so rdata stays stable mid-read.
                rdata_d = {rd_buf_q, bus_in};
                state_d = ST_IDLE;
            end
            ST_WR0:  state_d = ST_WR1;
            ST_WR1:  state_d = ST_WR2;
            ST_WR2:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        done_d  = (state_q == ST_RD2) || (state_q == ST_WR2);
        ready_d = (state_d == ST_IDLE);
        bus_d   = bus_enc(state_d, xfer_d);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            xfer_q   <= '0;
            hi_q     <= '0;
            hi_vld_q <= 1'b0;
            rd_buf_q <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            bus_q    <= BUS_IDLE;
        end else begin
            state_q  <= state_d;
            xfer_q   <= xfer_d;
            hi_q     <= hi_d;
            hi_vld_q <= hi_vld_d;
            rd_buf_q <= rd_buf_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            bus_q    <= bus_d;
        end
    end

    assign ready   = ready_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign bus_out = bus_q;

endmodule

// File: tb/tb_pdp8_membus_ctrl.sv
// Directed scoreboard bench for pdp8_membus_ctrl with an SRAM/IO pin model.
// Two instances: HI_CACHE=1 (main) and HI_CACHE=0; sel_nc picks which one
// the stimulus and the pin model talk to.
module tb_pdp8_membus_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, is_io, sel_nc;
    logic [11:0] addr, wdata;
    logic [4:0]  io_sel;
    logic [3:0]  bus_in;

    logic        req_a, ready_a, done_a;
    logic [11:0] rdata_a;
    logic [7:0]  bus_a;
    logic        req_b, ready_b, done_b;
    logic [11:0] rdata_b;
    logic [7:0]  bus_b;

    logic        ready_o, done_o;
    logic [11:0] rdata_o;
    logic [7:0]  bus_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          step  = 0;
    logic [11:0] last_rd;

    logic [7:0]  bus_q[$];
    logic [11:0] rd_q[$];

    always #5 clk = ~clk;

    assign req_a   = req & ~sel_nc;
    assign req_b   = req & sel_nc;
    assign ready_o = sel_nc ? ready_b : ready_a;
    assign done_o  = sel_nc ? done_b  : done_a;
    assign rdata_o = sel_nc ? rdata_b : rdata_a;
    assign bus_o   = sel_nc ? bus_b   : bus_a;

    pdp8_membus_ctrl #(.HI_CACHE(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .is_io(is_io),
        .addr(addr), .io_sel(io_sel), .wdata(wdata), .ready(ready_a),
        .done(done_a), .rdata(rdata_a), .bus_out(bus_a), .bus_in(bus_in)
    );

    pdp8_membus_ctrl #(.HI_CACHE(1'b0)) u_nc (
        .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .is_io(is_io),
        .addr(addr), .io_sel(io_sel), .wdata(wdata), .ready(ready_b),
        .done(done_b), .rdata(rdata_b), .bus_out(bus_b), .bus_in(bus_in)
    );

    // ---------------- pin-level SRAM / IO device model ----------------
    logic [11:0]   mem [0:4095];
    logic [4095:0] mem_v = '0;
    logic [11:0]   io_arr [0:31];
    logic [31:0]   io_v = '0;
    logic [5:0]    m_hi = '0, m_lo = '0;
    logic          m_io = 1'b0;
    logic [4:0]    m_sel = '0;
    logic [7:0]    m_wbuf = '0;
    logic [11:0]   m_word;

    function automatic logic [11:0] mem_pat(input logic [11:0] a);
        return ~a;
    endfunction

    function automatic logic [11:0] io_pat(input logic [4:0] s);
        return (s == 5'd2) ? 12'hA5C : {7'd0, s};
    endfunction

    always @(posedge clk) begin
        casez (bus_o)
            8'b11??????: m_hi <= bus_o[5:0];
            8'b10??????: begin m_lo <= bus_o[5:0]; m_io <= 1'b0; end
            8'b011?????: begin m_io <= 1'b1; m_sel <= bus_o[4:0]; end
            8'b0001????: m_wbuf[3:0] <= bus_o[3:0];
            8'b0011????: m_wbuf[7:4] <= bus_o[3:0];
            8'b0101????: begin
                if (m_io) begin
                    io_arr[m_sel] <= {bus_o[3:0], m_wbuf};
                    io_v[m_sel]   <= 1'b1;
                end else begin
                    mem[{m_hi, m_lo}]   <= {bus_o[3:0], m_wbuf};
                    mem_v[{m_hi, m_lo}] <= 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        if (m_io) m_word = io_v[m_sel] ? io_arr[m_sel] : io_pat(m_sel);
        else      m_word = mem_v[{m_hi, m_lo}] ? mem[{m_hi, m_lo}] : mem_pat({m_hi, m_lo});
        case (bus_o)
            8'h00:   bus_in = m_word[11:8];
            8'h20:   bus_in = m_word[7:4];
            8'h40:   bus_in = m_word[3:0];
            default: bus_in = 4'h0;
        endcase
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s (step %0d): observed %h expected %h", tag, step, obs, exp);
        end
    endtask

    // One transfer: push expected bus cycles/read word, drive, then pop and compare.
    task automatic do_xfer(input logic w, input logic io, input logic [11:0] a,
                           input logic [4:0] s, input logic [11:0] d, input logic hit,
                           input logic keep, input logic [11:0] exp_rd);
        int         cyc;
        int         exp_lat;
        logic [7:0] eb;
        step++;
        if (io) begin
            bus_q.push_back({3'b011, s});
        end else begin
            if (!hit) bus_q.push_back({2'b11, a[11:6]});
            bus_q.push_back({2'b10, a[5:0]});
        end
        if (w) begin
            bus_q.push_back({3'b000, 1'b1, d[3:0]});
            bus_q.push_back({3'b001, 1'b1, d[7:4]});
            bus_q.push_back({3'b010, 1'b1, d[11:8]});
        end else begin
            bus_q.push_back(8'h00);
            bus_q.push_back(8'h20);
            bus_q.push_back(8'h40);
            rd_q.push_back(exp_rd);
        end
        exp_lat = (io || hit) ? 5 : 6;

        chk("ready_before", 12'(ready_o), 12'd1);
        req = 1'b1; we = w; is_io = io; addr = a; io_sel = s; wdata = d;
        @(posedge clk);
        #1;
        if (!keep) req = 1'b0;
        // Scramble inputs: the controller must work from its captured copy.
        we = ~w; is_io = ~io; addr = ~a; io_sel = ~s; wdata = ~d;
        cyc = 1;
        @(negedge clk);
        while (bus_q.size() != 0) begin
            eb = bus_q.pop_front();
            chk("bus_out", 12'(bus_o), 12'(eb));
            chk("done_early", 12'(done_o), 12'd0);
            @(negedge clk);
            cyc++;
        end
        while (done_o !== 1'b1 && cyc < 12) begin
            @(negedge clk);
            cyc++;
        end
        chk("latency", 12'(cyc), 12'(exp_lat));
        chk("ready_done", 12'(ready_o), 12'd1);
        if (w) begin
            chk("rdata_hold", rdata_o, last_rd);
        end else begin
            last_rd = rd_q.pop_front();
            chk("rdata", rdata_o, last_rd);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; we = 1'b0; is_io = 1'b0; sel_nc = 1'b0;
        addr = '0; wdata = '0; io_sel = '0; last_rd = '0;

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_bus", 12'(bus_o), 12'h000);
        chk("rst_ready", 12'(ready_o), 12'd1);
        chk("rst_done", 12'(done_o), 12'd0);
        chk("rst_rdata", rdata_o, 12'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Memory write (page miss) then reads in the same page (hits).
        do_xfer(1'b1, 1'b0, 12'o1234, 5'd0, 12'o4321, 1'b0, 1'b0, 12'd0);
        do_xfer(1'b0, 1'b0, 12'o1234, 5'd0, 12'd0,    1'b1, 1'b0, 12'o4321);
        do_xfer(1'b0, 1'b0, 12'o1277, 5'd0, 12'd0,    1'b1, 1'b0, mem_pat(12'o1277));

        // IO read, IO write, IO read-back, then memory again (page still tracked).
        do_xfer(1'b0, 1'b1, 12'd0, 5'd2, 12'd0,   1'b0, 1'b0, 12'hA5C);
        do_xfer(1'b1, 1'b1, 12'd0, 5'd3, 12'h123, 1'b0, 1'b0, 12'd0);
        do_xfer(1'b0, 1'b1, 12'd0, 5'd3, 12'd0,   1'b0, 1'b0, 12'h123);
        do_xfer(1'b0, 1'b0, 12'o1234, 5'd0, 12'd0, 1'b1, 1'b0, 12'o4321);

        // Back-to-back with req held: next accept lands on the done cycle.
        do_xfer(1'b1, 1'b0, 12'o1240, 5'd0, 12'o7070, 1'b1, 1'b1, 12'd0);
        do_xfer(1'b0, 1'b0, 12'o1240, 5'd0, 12'd0,    1'b1, 1'b0, 12'o7070);

        // Reset during WR1 of a page-hit write.
        step++;
        chk("abort_ready", 12'(ready_o), 12'd1);
        req = 1'b1; we = 1'b1; is_io = 1'b0; addr = 12'o1250; wdata = 12'o1111; io_sel = '0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        chk("abort_llo", 12'(bus_o), 12'h0A8);
        @(negedge clk);
        chk("abort_wr0", 12'(bus_o), 12'h019);
        @(negedge clk);
        chk("abort_wr1", 12'(bus_o), 12'h034);
        rst_n = 1'b0;
        #1;
        chk("abort_bus", 12'(bus_o), 12'h000);
        chk("abort_rdy", 12'(ready_o), 12'd1);
        chk("abort_done", 12'(done_o), 12'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_nodone", 12'(done_o), 12'd0);
        end
        chk("abort_rdata", rdata_o, 12'd0);
        last_rd = 12'd0;
        // Page tracking was cleared, and the aborted write never committed.
        do_xfer(1'b0, 1'b0, 12'o1250, 5'd0, 12'd0, 1'b0, 1'b0, mem_pat(12'o1250));

        // HI_CACHE=0 instance: same-page reads always latch the high half.
        sel_nc = 1'b1;
        @(negedge clk);
        do_xfer(1'b0, 1'b0, 12'o1234, 5'd0, 12'd0, 1'b0, 1'b0, 12'o4321);
        do_xfer(1'b0, 1'b0, 12'o1234, 5'd0, 12'd0, 1'b0, 1'b0, 12'o4321);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
